// File: rtl/cpu_wb_scoreboard.sv
// Register-file write-back controller: busy-bit scoreboard with RAW/WAW issue stall and
// round-robin arbitration of the single write port between ALU and load results.
module cpu_wb_scoreboard #(
    parameter logic MORE_REGISTERS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    output logic        issue_stall,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic [4:0]  rf_addr_wr,
    output logic [31:0] rf_data_wr,
    output logic        rf_wr,
    output logic [31:0] busy,
    output logic        sb_err
);

    localparam logic GntAlu = 1'b0;
    localparam logic GntMem = 1'b1;

    // Reduced register file: anything with bit 4 set aliases to x0.
    function automatic logic [4:0] norm(input logic [4:0] a);
        norm = (!MORE_REGISTERS && a[4]) ? 5'd0 : a;
    endfunction

    logic [4:0]  rs1_n, rs2_n, rd_n, alu_rd_n, mem_rd_n;
    logic [31:0] busy_q, busy_d;
    logic        last_grant_q;
    logic [4:0]  rf_addr_wr_q;
    logic [31:0] rf_data_wr_q;
    logic        rf_wr_q;
    logic        sb_err_q;
    logic        issue_go;
    logic        alu_gnt, mem_gnt, any_gnt;
    logic [4:0]  gnt_rd;
    logic [31:0] gnt_data;

    assign rs1_n    = norm(issue_rs1);
    assign rs2_n    = norm(issue_rs2);
    assign rd_n     = norm(issue_rd);
    assign alu_rd_n = norm(alu_rd);
    assign mem_rd_n = norm(mem_rd);

    // Registered state only: a write committing this cycle does not unblock issue yet.
    assign issue_stall = issue_valid & (busy_q[rs1_n] | busy_q[rs2_n] | busy_q[rd_n]);
    assign issue_go    = issue_valid & ~issue_stall & (rd_n != 5'd0);

    assign alu_gnt  = alu_valid & (~mem_valid | (last_grant_q == GntMem));
    assign mem_gnt  = mem_valid & (~alu_valid | (last_grant_q == GntAlu));
    assign any_gnt  = alu_gnt | mem_gnt;
    assign gnt_rd   = mem_gnt ? mem_rd_n : alu_rd_n;
    assign gnt_data = mem_gnt ? mem_data : alu_data;

    assign alu_ready = alu_gnt;
    assign mem_ready = mem_gnt;

    // Clear first so a same-index issue set takes precedence.
    always_comb begin
        busy_d = busy_q;
        if (rf_wr_q) begin
            busy_d[rf_addr_wr_q] = 1'b0;
        end
        if (issue_go) begin
            busy_d[rd_n] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            last_grant_q <= GntAlu;
            rf_addr_wr_q <= '0;
            rf_data_wr_q <= '0;
            rf_wr_q      <= 1'b0;
            sb_err_q     <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            rf_wr_q <= any_gnt & (gnt_rd != 5'd0);
            if (any_gnt) begin
                last_grant_q <= mem_gnt ? GntMem : GntAlu;
                rf_addr_wr_q <= gnt_rd;
                rf_data_wr_q <= gnt_data;
                if ((gnt_rd != 5'd0) && !busy_q[gnt_rd]) begin
                    sb_err_q <= 1'b1;
                end
            end
        end
    end

    assign busy       = busy_q;
    assign rf_addr_wr = rf_addr_wr_q;
    assign rf_data_wr = rf_data_wr_q;
    assign rf_wr      = rf_wr_q;
    assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_cpu_wb_scoreboard.sv
// Directed bench for cpu_wb_scoreboard: vector table for single-cycle behaviour plus
// hand sequences for reset-with-pending-grant and the reduced register file.
module tb_cpu_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;

    logic        issue_stall, alu_ready, mem_ready, rf_wr, sb_err;
    logic [4:0]  rf_addr_wr;
    logic [31:0] rf_data_wr, busy;

    logic        issue_stall0, alu_ready0, mem_ready0, rf_wr0, sb_err0;
    logic [4:0]  rf_addr_wr0;
    logic [31:0] rf_data_wr0, busy0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_wb_scoreboard #(.MORE_REGISTERS(1'b1)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_addr_wr(rf_addr_wr), .rf_data_wr(rf_data_wr), .rf_wr(rf_wr),
        .busy(busy), .sb_err(sb_err)
    );

    cpu_wb_scoreboard #(.MORE_REGISTERS(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_stall(issue_stall0),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready0),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready0),
        .rf_addr_wr(rf_addr_wr0), .rf_data_wr(rf_data_wr0), .rf_wr(rf_wr0),
        .busy(busy0), .sb_err(sb_err0)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  rs1, rs2, rd;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        e_stall, e_ar, e_mr;
        logic        e_wr;
        logic [4:0]  e_addr;
        logic [31:0] e_data, e_busy;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic iv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic av, input logic [4:0] ard, input logic [31:0] adat,
        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
        input logic e_stall, input logic e_ar, input logic e_mr,
        input logic e_wr, input logic [4:0] e_addr, input logic [31:0] e_data,
        input logic [31:0] e_busy, input logic e_err);
        vec_t v;
        v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.av = av; v.ard = ard; v.adat = adat;
        v.mv = mv; v.mrd = mrd; v.mdat = mdat;
        v.e_stall = e_stall; v.e_ar = e_ar; v.e_mr = e_mr;
        v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
        v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
    endtask

    initial begin
        // iv rs1 rs2 rd | av ard adat | mv mrd mdat | stall ar mr | wr addr data busy err
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 0));
        vecs.push_back(mk(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h28, 0));
        vecs.push_back(mk(1, 5, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0,
                          1, 1, 0, 1, 5, 32'hDEADBEEF, 32'h28, 0));
        vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 32'hDEADBEEF, 32'h8, 0));
        vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 32'h8, 0));
        vecs.push_back(mk(1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 32'h18, 0));
        vecs.push_back(mk(1, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 32'h58, 0));
        // Tie after reset: MEM first, then ALU
        vecs.push_back(mk(0, 0, 0, 0, 1, 4, 32'h44444444, 1, 6, 32'h66666666,
                          0, 0, 1, 1, 6, 32'h66666666, 32'h58, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4, 32'h44444444, 0, 0, 0,
                          0, 1, 0, 1, 4, 32'h44444444, 32'h18, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 32'h44444444, 32'h8, 0));
        vecs.push_back(mk(1, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 32'h44444444, 32'h108, 0));
        vecs.push_back(mk(1, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 32'h44444444, 32'h308, 0));
        vecs.push_back(mk(1, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 32'h44444444, 32'h708, 0));
        vecs.push_back(mk(1, 0, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 32'h44444444, 32'hF08, 0));
        // Both held valid four cycles: MEM, ALU, MEM, ALU
        vecs.push_back(mk(0, 0, 0, 0, 1, 8, 32'hA8, 1, 9, 32'h99, 0, 0, 1, 1, 9, 32'h99, 32'hF08, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 8, 32'hA8, 1, 11, 32'hBB, 0, 1, 0, 1, 8, 32'hA8, 32'hD08, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 10, 32'hAA, 1, 11, 32'hBB, 0, 0, 1, 1, 11, 32'hBB, 32'hC08, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 10, 32'hAA, 1, 0, 32'h12345678,
                          0, 1, 0, 1, 10, 32'hAA, 32'h408, 0));
        // rd=0 grant: handshake but no write
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h12345678,
                          0, 0, 1, 0, 0, 32'h12345678, 32'h8, 0));
        // Write-back to non-pending register: sticky error
        vecs.push_back(mk(0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 0, 1, 0, 1, 7, 32'h77, 32'h8, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 12, 32'hC, 0, 0, 0, 0, 1, 0, 1, 12, 32'hC, 32'h8, 1));
        // Issue rd=12 while its commit clears it: set wins
        vecs.push_back(mk(1, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 32'hC, 32'h1008, 1));
        // Stalled issue must not set busy
        vecs.push_back(mk(1, 3, 0, 13, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 12, 32'hC, 32'h1008, 1));

        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        foreach (vecs[i]) begin
            issue_valid = vecs[i].iv; issue_rs1 = vecs[i].rs1;
            issue_rs2 = vecs[i].rs2; issue_rd = vecs[i].rd;
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat;
            mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].mdat;
            #1;
            chk($sformatf("v%0d stall", i), {31'b0, issue_stall}, {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d alu_ready", i), {31'b0, alu_ready}, {31'b0, vecs[i].e_ar});
            chk($sformatf("v%0d mem_ready", i), {31'b0, mem_ready}, {31'b0, vecs[i].e_mr});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rf_wr", i), {31'b0, rf_wr}, {31'b0, vecs[i].e_wr});
            chk($sformatf("v%0d rf_addr", i), {27'b0, rf_addr_wr}, {27'b0, vecs[i].e_addr});
            chk($sformatf("v%0d rf_data", i), rf_data_wr, vecs[i].e_data);
            chk($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d sb_err", i), {31'b0, sb_err}, {31'b0, vecs[i].e_err});
        end

        // Reset while busy[3]=1 and an ALU grant is pending
        idle_inputs();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        rst = 1;
        @(posedge clk);
        #1;
        chk("rst busy", busy, 32'h0);
        chk("rst rf_wr", {31'b0, rf_wr}, 32'h0);
        chk("rst sb_err", {31'b0, sb_err}, 32'h0);
        chk("rst rf_addr", {27'b0, rf_addr_wr}, 32'h0);
        chk("rst rf_data", rf_data_wr, 32'h0);
        rst = 0;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("post-rst rf_wr", {31'b0, rf_wr}, 32'h0);
        chk("post-rst busy", busy, 32'h0);

        // Reduced register file: x17 aliases to x0 on dut0
        issue_valid = 1; issue_rd = 17;
        #1;
        chk("r17 stall full", {31'b0, issue_stall}, 32'h0);
        chk("r17 stall small", {31'b0, issue_stall0}, 32'h0);
        @(posedge clk);
        #1;
        chk("r17 busy full", busy, 32'h20000);
        chk("r17 busy small", busy0, 32'h0);
        issue_rs1 = 17; issue_rd = 0;
        alu_valid = 1; alu_rd = 17; alu_data = 32'h1717;
        #1;
        chk("r17 rs stall full", {31'b0, issue_stall}, 32'h1);
        chk("r17 rs stall small", {31'b0, issue_stall0}, 32'h0);
        chk("r17 ready small", {31'b0, alu_ready0}, 32'h1);
        @(posedge clk);
        #1;
        chk("r17 wr full", {31'b0, rf_wr}, 32'h1);
        chk("r17 wr small", {31'b0, rf_wr0}, 32'h0);
        chk("r17 addr small", {27'b0, rf_addr_wr0}, 32'h0);
        chk("r17 err small", {31'b0, sb_err0}, 32'h0);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
